// File: rtl/binary_search_engine.sv
// Sequential binary search (exact match / lower bound) over an external sorted memory.
// Optional BSEARCH_PROBE_CNT_EN adds a 'probes' output counting reads of the current search.
module binary_search_engine #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 5,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s,
   input  logic [DATA_W-1:0] tin,
   input  logic              mode,
   input  logic [DATA_W-1:0] din,
   output logic [ADDR_W-1:0] addo,
   output logic              rd_en,
   output logic              found,
   output logic              done,
   output logic [ADDR_W-1:0] addf
`ifdef BSEARCH_PROBE_CNT_EN
   ,
   output logic [ADDR_W:0]   probes
`endif
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_LAT - 1);
   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT,
      S_CMP,
      S_FIN,
      S_DONE
   } state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] t_q, t_n;
   logic              m_q, m_n;
   logic [ADDR_W:0]   lo, lo_n, hi, hi_n, mid;
   logic [CW-1:0]     wcnt, wcnt_n;
   logic [ADDR_W-1:0] addo_n, addf_n;
   logic              rd_en_n, found_n, done_n;

   // [lo, hi) never exceeds 2**ADDR_W while lo < hi, so the sum fits in ADDR_W+1 bits.
   assign mid = (lo + hi) >> 1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         t_q   <= '0;
         m_q   <= 1'b0;
         lo    <= '0;
         hi    <= '0;
         wcnt  <= '0;
         addo  <= '0;
         rd_en <= 1'b0;
         found <= 1'b0;
         done  <= 1'b0;
         addf  <= '0;
      end else begin
         state <= state_n;
         t_q   <= t_n;
         m_q   <= m_n;
         lo    <= lo_n;
         hi    <= hi_n;
         wcnt  <= wcnt_n;
         addo  <= addo_n;
         rd_en <= rd_en_n;
         found <= found_n;
         done  <= done_n;
         addf  <= addf_n;
      end
   end

   always_comb begin
      state_n = state;
      t_n     = t_q;
      m_n     = m_q;
      lo_n    = lo;
      hi_n    = hi;
      wcnt_n  = wcnt;
      addo_n  = addo;
      rd_en_n = 1'b0;
      found_n = found;
      done_n  = done;
      addf_n  = addf;
      case (state)
         S_IDLE: begin
            if (s) begin
               t_n     = tin;
               m_n     = mode;
               lo_n    = '0;
               hi_n    = DEPTH;
               found_n = 1'b0;
               addf_n  = '0;
               done_n  = 1'b0;
               state_n = S_CALC;
            end
         end
         S_CALC: begin
            if (lo < hi) begin
               addo_n  = mid[ADDR_W-1:0];
               rd_en_n = 1'b1;
               wcnt_n  = '0;
               state_n = S_WAIT;
            end else begin
               state_n = S_FIN;
            end
         end
         S_WAIT: begin
            if (wcnt == WAIT_LAST) state_n = S_CMP;
            else                   wcnt_n  = wcnt + CW'(1);
         end
         S_CMP: begin
            if (!m_q && (din == t_q)) begin
               found_n = 1'b1;
               addf_n  = mid[ADDR_W-1:0];
               state_n = S_FIN;
            end else begin
               // Lower-bound mode treats equality like "greater" to keep narrowing left.
               if (din < t_q) lo_n = mid + ONE;
               else           hi_n = mid;
               state_n = S_CALC;
            end
         end
         S_FIN: begin
            if (m_q) begin
               found_n = ~lo[ADDR_W];
               addf_n  = lo[ADDR_W] ? '0 : lo[ADDR_W-1:0];
            end
            done_n  = 1'b1;
            state_n = S_DONE;
         end
         S_DONE: begin
            if (!s) begin
               done_n  = 1'b0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

`ifdef BSEARCH_PROBE_CNT_EN
   always_ff @(posedge clock) begin
      if (reset)                        probes <= '0;
      else if ((state == S_IDLE) && s)  probes <= '0;
      else if ((state == S_CALC) && (lo < hi)) probes <= probes + ONE;
   end
`endif

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench: two engines (MEM_LAT=1 and MEM_LAT=3) over mem[i]=2*i, table vectors plus corner sequences.
module tb_binary_search_engine;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              s_a = 1'b0, s_b = 1'b0;
   logic [DATA_W-1:0] tin = '0;
   logic              mode = 1'b0;
   logic [DATA_W-1:0] din_a = '0, din_b = '0;
   logic [ADDR_W-1:0] addo_a, addo_b, addf_a, addf_b;
   logic              rd_en_a, rd_en_b, found_a, found_b, done_a, done_b;
`ifdef BSEARCH_PROBE_CNT_EN
   logic [ADDR_W:0]   probes_a, probes_b;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   int rd_tot_a = 0, rd_tot_b = 0;
   int rd_dbl = 0;
   logic rd_prev_a = 1'b0, rd_prev_b = 1'b0;

   always #5 clock = ~clock;

   binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(1)) dut_a (
      .clock(clock), .reset(reset), .s(s_a), .tin(tin), .mode(mode), .din(din_a),
      .addo(addo_a), .rd_en(rd_en_a), .found(found_a), .done(done_a), .addf(addf_a)
`ifdef BSEARCH_PROBE_CNT_EN
      , .probes(probes_a)
`endif
   );

   binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(3)) dut_b (
      .clock(clock), .reset(reset), .s(s_b), .tin(tin), .mode(mode), .din(din_b),
      .addo(addo_b), .rd_en(rd_en_b), .found(found_b), .done(done_b), .addf(addf_b)
`ifdef BSEARCH_PROBE_CNT_EN
      , .probes(probes_b)
`endif
   );

   function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      return DATA_W'(2 * int'(a));
   endfunction

   // Memory A: one-cycle synchronous read.
   always @(posedge clock) if (rd_en_a) din_a <= mem_val(addo_a);

   // Memory B: data valid only exactly 3 cycles after rd_en, garbage otherwise.
   logic              vb0 = 1'b0, vb1 = 1'b0;
   logic [ADDR_W-1:0] ab0 = '0, ab1 = '0;
   always @(posedge clock) begin
      vb0   <= rd_en_b;
      ab0   <= addo_b;
      vb1   <= vb0;
      ab1   <= ab0;
      din_b <= vb1 ? mem_val(ab1) : DATA_W'($urandom);
   end

   always @(posedge clock) begin
      if (rd_en_a) rd_tot_a <= rd_tot_a + 1;
      if (rd_en_b) rd_tot_b <= rd_tot_b + 1;
      if ((rd_en_a && rd_prev_a) || (rd_en_b && rd_prev_b)) rd_dbl <= rd_dbl + 1;
      rd_prev_a <= rd_en_a;
      rd_prev_b <= rd_en_b;
   end

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Start a search, wait for done, check result, hold s high, then release.
   task automatic run_search(input bit use_b, input string tag, input logic [DATA_W-1:0] t,
                             input logic m, input int exp_found, input int exp_addf,
                             input int exp_reads, input int exp_cyc);
      int rd0;
      int cyc;
      bit got;
      @(negedge clock);
      rd0 = use_b ? rd_tot_b : rd_tot_a;
      tin = t;
      mode = m;
      if (use_b) s_b = 1'b1; else s_a = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clock);
         cyc++;
         got = use_b ? done_b : done_a;
      end
      chk({tag, " done"}, int'(got), 1);
      chk({tag, " latency"}, cyc, exp_cyc);
      chk({tag, " found"}, int'(use_b ? found_b : found_a), exp_found);
      chk({tag, " addf"}, int'(use_b ? addf_b : addf_a), exp_addf);
      chk({tag, " reads"}, (use_b ? rd_tot_b : rd_tot_a) - rd0, exp_reads);
`ifdef BSEARCH_PROBE_CNT_EN
      chk({tag, " probes"}, int'(use_b ? probes_b : probes_a), (use_b ? rd_tot_b : rd_tot_a) - rd0);
`endif
      repeat (3) @(negedge clock);
      chk({tag, " hold done"}, int'(use_b ? done_b : done_a), 1);
      chk({tag, " hold found"}, int'(use_b ? found_b : found_a), exp_found);
      chk({tag, " hold addf"}, int'(use_b ? addf_b : addf_a), exp_addf);
      if (use_b) s_b = 1'b0; else s_a = 1'b0;
      @(negedge clock);
      chk({tag, " release done"}, int'(use_b ? done_b : done_a), 0);
      chk({tag, " release found"}, int'(use_b ? found_b : found_a), exp_found);
      chk({tag, " release addf"}, int'(use_b ? addf_b : addf_a), exp_addf);
   endtask

   typedef struct {
      logic [DATA_W-1:0] t;
      logic              m;
      int                f;
      int                a;
      int                reads;
      int                cyc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int cyc;
      bit got;

      // Latency in negedges after start: hit = reads*3+2, lower-bound/miss = reads*3+3.
      vecs[0] = '{t: 8'd40, m: 1'b0, f: 1, a: 20, reads: 3, cyc: 11};
      vecs[1] = '{t: 8'd41, m: 1'b0, f: 0, a: 0,  reads: 5, cyc: 18};
      vecs[2] = '{t: 8'd41, m: 1'b1, f: 1, a: 21, reads: 5, cyc: 18};
      vecs[3] = '{t: 8'd0,  m: 1'b1, f: 1, a: 0,  reads: 6, cyc: 21};
      vecs[4] = '{t: 8'd62, m: 1'b1, f: 1, a: 31, reads: 5, cyc: 18};
      vecs[5] = '{t: 8'd63, m: 1'b1, f: 0, a: 0,  reads: 5, cyc: 18};
      vecs[6] = '{t: 8'd10, m: 1'b0, f: 1, a: 5,  reads: 5, cyc: 17};

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("reset found", int'(found_a), 0);
      chk("reset done", int'(done_a), 0);
      chk("reset addf", int'(addf_a), 0);
      chk("reset addo", int'(addo_a), 0);
      chk("reset rd_en", int'(rd_en_a), 0);

      for (int i = 0; i < 7; i++)
         run_search(1'b0, $sformatf("vec%0d", i), vecs[i].t, vecs[i].m, vecs[i].f,
                    vecs[i].a, vecs[i].reads, vecs[i].cyc);

      // Three-cycle memory with garbage on din outside the valid cycle: 5 probes of 5 cycles.
      run_search(1'b1, "lat3", 8'd2, 1'b0, 1, 1, 5, 27);

      // Reset during the second probe's WAIT aborts the search.
      @(negedge clock);
      tin = 8'd40;
      mode = 1'b0;
      s_a = 1'b1;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      s_a = 1'b0;
      @(negedge clock);
      chk("midreset found", int'(found_a), 0);
      chk("midreset done", int'(done_a), 0);
      chk("midreset addf", int'(addf_a), 0);
      chk("midreset addo", int'(addo_a), 0);
      chk("midreset rd_en", int'(rd_en_a), 0);
      reset = 1'b0;
      repeat (20) @(negedge clock);
      chk("aborted no done", int'(done_a), 0);
      run_search(1'b0, "after_reset", 8'd10, 1'b0, 1, 5, 5, 17);

      // Inputs changed and s dropped mid-search: result must follow the latched target.
      @(negedge clock);
      tin = 8'd40;
      mode = 1'b0;
      s_a = 1'b1;
      repeat (2) @(negedge clock);
      tin = 8'd0;
      mode = 1'b1;
      s_a = 1'b0;
      cyc = 2;
      got = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clock);
         cyc++;
         got = done_a;
      end
      chk("drop done", int'(got), 1);
      chk("drop latency", cyc, 11);
      chk("drop found", int'(found_a), 1);
      chk("drop addf", int'(addf_a), 20);
`ifdef BSEARCH_PROBE_CNT_EN
      chk("drop probes", int'(probes_a), 3);
`endif
      @(negedge clock);
      chk("drop back idle", int'(done_a), 0);
      chk("drop kept addf", int'(addf_a), 20);

      chk("rd_en single cycle", rd_dbl, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
